// File: rtl/match_score_keeper.sv
// match_score_keeper: game-mode FSM plus score, strike and inactivity-timeout
// bookkeeping for the memory-tile game. All outputs come straight from flops
// so the downstream display decoder sees glitch-free, edge-aligned values.
module match_score_keeper #(
    parameter int MAX_STRIKES    = 3,          // misses allowed before game over (1..8)
    parameter int WIN_SCORE      = 32,         // binary score that ends the game as a win (1..99)
    parameter int TIMEOUT_CYCLES = 250000000   // idle PLAY cycles before an automatic miss
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic       start,
    input  logic       quit,
    input  logic       match_valid,
    input  logic       match_hit,
    output logic       user_quit,
    output logic       ingame_on,
    output logic       game_over,
    output logic       won,
    output logic [3:0] hex0_code,
    output logic [3:0] score_ones,
    output logic [3:0] score_tens,
    output logic [7:0] dementia_score,
    output logic [9:0] ledr
);

    localparam int            TW           = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_RELOAD = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]    SCORE_MAX    = 8'd99;

    // State encodings double as the HEX0 mode code; 4'hF is reserved as blank.
    typedef enum logic [3:0] {
        S_IDLE = 4'h0,
        S_PLAY = 4'h1,
        S_QUIT = 4'hD,
        S_OVER = 4'hE
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    score_q, score_d;
    logic [3:0]    ones_q, ones_d;
    logic [3:0]    tens_q, tens_d;
    logic [3:0]    strikes_q, strikes_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          won_q, won_d;
    logic [9:0]    ledr_d;
    logic          hit_event;
    logic          miss_event;

    // Next-state and next-score logic; quit outranks match_valid, which
    // outranks timer expiry.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d    = state_q;
        score_d    = score_q;
        ones_d     = ones_q;
        tens_d     = tens_q;
        strikes_d  = strikes_q;
        timer_d    = timer_q;
        won_d      = won_q;
        hit_event  = 1'b0;
        miss_event = 1'b0;

        unique case (state_q)
            S_IDLE, S_OVER, S_QUIT: begin
                if (start) begin
                    state_d   = S_PLAY;
                    score_d   = '0;
                    ones_d    = '0;
                    tens_d    = '0;
                    strikes_d = '0;
                    won_d     = 1'b0;
                    timer_d   = TIMER_RELOAD;
                end
            end

            S_PLAY: begin
                if (quit) begin
                    // A coincident attempt is dropped; the timer is irrelevant
                    // until the next start reloads it.
                    state_d = S_QUIT;
                end else if (match_valid) begin
                    timer_d    = TIMER_RELOAD;
                    hit_event  = match_hit;
                    miss_event = !match_hit;
                end else if (timer_q == '0) begin
                    timer_d    = TIMER_RELOAD;
                    miss_event = 1'b1;
                end else begin
                    timer_d = timer_q - TW'(1);
                end

                // Binary and BCD scores move together, so one saturation
                // test on the binary copy covers both.
                if (hit_event && (score_q != SCORE_MAX)) begin
                    score_d = score_q + 8'd1;
                    if (ones_q == 4'd9) begin
                        ones_d = 4'd0;
                        tens_d = tens_q + 4'd1;
                    end else begin
                        ones_d = ones_q + 4'd1;
                    end
                end

                if (hit_event && (score_d == 8'(WIN_SCORE))) begin
                    state_d = S_OVER;
                    won_d   = 1'b1;
                end

                if (miss_event) begin
                    strikes_d = strikes_q + 4'd1;
                    if (strikes_d == 4'(MAX_STRIKES)) begin
                        state_d = S_OVER;
                        won_d   = 1'b0;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // LED pattern for the upcoming state: mode flags on top, lives thermometer
    // at the bottom. With MAX_STRIKES=8 bit 7 is shared, so the two are ORed.
    always_comb begin
        ledr_d = '0;
        if (state_d != S_IDLE) begin
            for (int i = 0; i < MAX_STRIKES; i++) begin
                ledr_d[i] = (i < (MAX_STRIKES - int'(strikes_d)));
            end
            ledr_d[9] = (state_d == S_PLAY);
            ledr_d[8] = (state_d == S_OVER);
            ledr_d[7] = ledr_d[7] | won_d;
        end
    end

    // State, score and timer registers plus registered display flags.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            score_q   <= '0;
            ones_q    <= '0;
            tens_q    <= '0;
            strikes_q <= '0;
            timer_q   <= '0;
            won_q     <= 1'b0;
            user_quit <= 1'b0;
            ingame_on <= 1'b0;
            game_over <= 1'b0;
            ledr      <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples the pre-edge values regardless of statement order.
            state_q   <= state_d;
            score_q   <= score_d;
            ones_q    <= ones_d;
            tens_q    <= tens_d;
            strikes_q <= strikes_d;
            timer_q   <= timer_d;
            won_q     <= won_d;
            user_quit <= (state_d == S_QUIT);
            ingame_on <= (state_d == S_PLAY);
            game_over <= (state_d == S_OVER);
            ledr      <= ledr_d;
        end
    end

    assign hex0_code      = state_q;
    assign score_ones     = ones_q;
    assign score_tens     = tens_q;
    assign dementia_score = score_q;
    assign won            = won_q;

endmodule

// File: tb/tb_match_score_keeper.sv
// Directed bench for match_score_keeper with a short timeout so the
// inactivity path is reachable. A rules-level model tracks game mode, score,
// strikes and idle cycles; a negedge process compares every DUT output to it.
module tb_match_score_keeper;

    localparam int MAXS = 3;
    localparam int WIN  = 32;
    localparam int TO   = 10;

    logic       CLOCK_50 = 1'b0;
    logic       resetn = 1'b0;
    logic       start = 1'b0;
    logic       quit = 1'b0;
    logic       match_valid = 1'b0;
    logic       match_hit = 1'b0;
    logic       user_quit, ingame_on, game_over, won;
    logic [3:0] hex0_code, score_ones, score_tens;
    logic [7:0] dementia_score;
    logic [9:0] ledr;

    int vectors = 0;
    int miscompares = 0;

    match_score_keeper #(
        .MAX_STRIKES   (MAXS),
        .WIN_SCORE     (WIN),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .CLOCK_50      (CLOCK_50),
        .resetn        (resetn),
        .start         (start),
        .quit          (quit),
        .match_valid   (match_valid),
        .match_hit     (match_hit),
        .user_quit     (user_quit),
        .ingame_on     (ingame_on),
        .game_over     (game_over),
        .won           (won),
        .hex0_code     (hex0_code),
        .score_ones    (score_ones),
        .score_tens    (score_tens),
        .dementia_score(dementia_score),
        .ledr          (ledr)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef enum {M_IDLE, M_PLAY, M_OVER, M_QUIT} mmode_t;
    mmode_t m_mode    = M_IDLE;
    int     m_score   = 0;
    int     m_strikes = 0;
    int     m_idle    = 0;   // PLAY cycles since entry or last attempt
    bit     m_won     = 1'b0;

    task automatic m_new_game();
        m_mode = M_PLAY; m_score = 0; m_strikes = 0; m_idle = 0; m_won = 1'b0;
    endtask

    task automatic m_miss();
        m_strikes++;
        if (m_strikes == MAXS) begin
            m_mode = M_OVER;
            m_won  = 1'b0;
        end
    endtask

    always @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            m_mode = M_IDLE; m_score = 0; m_strikes = 0; m_idle = 0; m_won = 1'b0;
        end else begin
            case (m_mode)
                M_PLAY: begin
                    if (quit) begin
                        m_mode = M_QUIT;
                    end else if (match_valid) begin
                        m_idle = 0;
                        if (match_hit) begin
                            if (m_score < 99) m_score++;
                            if (m_score == WIN) begin
                                m_mode = M_OVER;
                                m_won  = 1'b1;
                            end
                        end else begin
                            m_miss();
                        end
                    end else begin
                        m_idle++;
                        if (m_idle == TO) begin
                            m_idle = 0;
                            m_miss();
                        end
                    end
                end
                default: if (start) m_new_game();
            endcase
        end
    end

    function automatic logic [33:0] model_outputs();
        logic [3:0] code;
        logic [9:0] led;
        case (m_mode)
            M_PLAY:  code = 4'h1;
            M_OVER:  code = 4'hE;
            M_QUIT:  code = 4'hD;
            default: code = 4'h0;
        endcase
        led = '0;
        if (m_mode != M_IDLE) begin
            led    = (10'd1 << (MAXS - m_strikes)) - 10'd1;
            led[9] = (m_mode == M_PLAY);
            led[8] = (m_mode == M_OVER);
            led[7] = led[7] | m_won;
        end
        return {m_mode == M_QUIT, m_mode == M_PLAY, m_mode == M_OVER, m_won, code,
                4'(m_score / 10), 4'(m_score % 10), 8'(m_score), led};
    endfunction

    // Every-cycle comparison, away from the active edge.
    always @(negedge CLOCK_50) begin
        check("cycle", 64'({user_quit, ingame_on, game_over, won, hex0_code,
                            score_tens, score_ones, dementia_score, ledr}),
              64'(model_outputs()));
    end

    // ---------------- stimulus ----------------
    // Called just after a negedge; the pulse is sampled on the next posedge.
    task automatic drive(input bit s, input bit q, input bit v, input bit h);
        start = s; quit = q; match_valid = v; match_hit = h;
        @(negedge CLOCK_50);
        start = 1'b0; quit = 1'b0; match_valid = 1'b0; match_hit = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle(2);
        resetn = 1'b1;
        idle(1);
        check("reset_hex0", 64'(hex0_code), 64'h0);
        check("reset_ledr", 64'(ledr), 64'h0);

        // Mid-PLAY asynchronous reset with score 5.
        drive(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) drive(0, 0, 1, 1);
        check("pre_reset_score", 64'(dementia_score), 64'd5);
        #2 resetn = 1'b0;
        #1;
        check("async_reset_flags", 64'({user_quit, ingame_on, game_over, won}), 64'h0);
        check("async_reset_hex0", 64'(hex0_code), 64'h0);
        check("async_reset_digits", 64'({score_tens, score_ones}), 64'h00);
        check("async_reset_score", 64'(dementia_score), 64'h0);
        check("async_reset_ledr", 64'(ledr), 64'h0);
        @(negedge CLOCK_50);
        resetn = 1'b1;
        idle(1);

        // 12 hits spaced 3 cycles apart.
        drive(1, 0, 0, 0);
        for (int i = 0; i < 12; i++) begin
            drive(0, 0, 1, 1);
            idle(2);
        end
        check("h12_ingame", 64'(ingame_on), 64'h1);
        check("h12_hex0", 64'(hex0_code), 64'h1);
        check("h12_tens", 64'(score_tens), 64'd1);
        check("h12_ones", 64'(score_ones), 64'd2);
        check("h12_score", 64'(dementia_score), 64'd12);
        check("h12_ledr", 64'(ledr), 64'(10'b10_0000_0111));

        // quit with a coincident hit, then quit outside PLAY.
        drive(0, 1, 1, 1);
        check("quit_flag", 64'(user_quit), 64'h1);
        check("quit_hex0", 64'(hex0_code), 64'hD);
        check("quit_score", 64'(dementia_score), 64'd12);
        drive(0, 1, 0, 0);
        check("quit_in_quit_hex0", 64'(hex0_code), 64'hD);

        // Fresh game, 3 misses (the first with an ignored start).
        drive(1, 0, 0, 0);
        check("restart_score", 64'(dementia_score), 64'd0);
        drive(1, 0, 1, 0);
        idle(1);
        drive(0, 0, 1, 0);
        idle(1);
        drive(0, 0, 1, 0);
        check("miss3_over", 64'(game_over), 64'h1);
        check("miss3_won", 64'(won), 64'h0);
        check("miss3_hex0", 64'(hex0_code), 64'hE);
        check("miss3_ledr", 64'(ledr), 64'(10'b01_0000_0000));
        drive(0, 0, 1, 1);
        check("over_hit_ignored", 64'(dementia_score), 64'd0);
        drive(0, 1, 0, 0);
        check("over_quit_ignored", 64'(hex0_code), 64'hE);

        // 32 hits -> win.
        drive(1, 0, 0, 0);
        for (int i = 0; i < 32; i++) begin
            drive(0, 0, 1, 1);
            if (i != 31) idle(1);
        end
        check("win_over", 64'(game_over), 64'h1);
        check("win_won", 64'(won), 64'h1);
        check("win_digits", 64'({score_tens, score_ones}), 64'h32);
        check("win_ledr", 64'(ledr), 64'(10'b01_1000_0111));

        // Restart, then inactivity timeouts.
        drive(1, 0, 0, 0);
        check("win_restart_digits", 64'({score_tens, score_ones}), 64'h00);
        check("win_restart_won", 64'(won), 64'h0);
        check("win_restart_hex0", 64'(hex0_code), 64'h1);
        idle(9);
        check("to_before_expiry", 64'(ledr), 64'(10'b10_0000_0111));
        idle(1);
        check("to_strike1", 64'(ledr), 64'(10'b10_0000_0011));
        idle(9);
        drive(0, 0, 1, 1);   // coincides with the second expiry
        check("to_coincident_ledr", 64'(ledr), 64'(10'b10_0000_0011));
        check("to_coincident_score", 64'(dementia_score), 64'd1);
        idle(9);
        check("to_reloaded", 64'(ledr), 64'(10'b10_0000_0011));
        idle(1);
        check("to_strike2", 64'(ledr), 64'(10'b10_0000_0001));
        idle(10);
        check("to_over_hex0", 64'(hex0_code), 64'hE);
        check("to_over_won", 64'(won), 64'h0);
        check("to_over_ledr", 64'(ledr), 64'(10'b01_0000_0000));

        // Back to IDLE: quit there is ignored.
        resetn = 1'b0;
        idle(1);
        resetn = 1'b1;
        drive(0, 1, 0, 0);
        check("idle_quit_hex0", 64'(hex0_code), 64'h0);
        idle(1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
